// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload bus between two pipeline stages.
//   valid  : producer holds a valid payload
//   ready  : consumer accepts a payload this cycle
//   data   : opaque payload, DATA_W bits
// master = producer side (drives valid/data), slave = consumer side (drives ready).
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline-stage register with a 2-entry skid buffer.
// in_ready is a pure register output, so the upstream stall path is cut.
// A synchronous flush empties the stage and drops any same-cycle input.
// A saturating counter reports how many valid entries flushes have killed.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous kill of stage contents and same-cycle input
//   up         upstream bus (slave):  valid/data in, ready out
//   dn         downstream bus (master): valid/data out, ready in
//   occupancy  entries held: 0, 1 or 2
//   kill_cnt   valid entries discarded by flush, saturating at all-ones
module pipe_stage_skid #(
    parameter int unsigned DATA_W      = 32,
    parameter bit          ZERO_BUBBLE = 1'b1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     kill_cnt
);

    // Two extra bits hold counter + largest per-cycle increment (2) without wrap.
    localparam int unsigned  SUM_W   = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [1:0]          occupancy_q, occupancy_d;
    logic [CNT_W-1:0]    kill_q, kill_d;
    logic [SUM_W-1:0]    kill_sum_c;
    logic                in_fire_c;
    logic                out_fire_c;

    assign in_fire_c  = up.valid & in_ready_q;
    assign out_fire_c = out_valid_q & dn.ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other event.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire_c) state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (in_fire_c && !out_fire_c)      state_d = ST_FULL;
                    else if (!in_fire_c && out_fire_c) state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (out_fire_c) state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occupancy_d = 2'd0;
        out_data_d  = '0;
        kill_d      = kill_q;

        // Data regs are left untouched by flush; out_valid alone marks the bubble.
        if (!flush) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire_c) main_d = up.data;
                end
                ST_ONE: begin
                    if (in_fire_c && out_fire_c) main_d = up.data;
                    else if (in_fire_c)          skid_d = up.data;
                end
                ST_FULL: begin
                    if (out_fire_c) main_d = skid_q;
                end
                default: ;
            endcase
        end

        unique case (state_d)
            ST_ONE: begin
                out_valid_d = 1'b1;
                occupancy_d = 2'd1;
            end
            ST_FULL: begin
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
                occupancy_d = 2'd2;
            end
            default: ;
        endcase

        if (ZERO_BUBBLE && (state_d == ST_EMPTY)) begin
            out_data_d = '0;
        end else begin
            out_data_d = main_d;
        end

        // Entries killed = held entries not leaving downstream + the dropped input.
        kill_sum_c = SUM_W'(kill_q) + SUM_W'(occupancy_q)
                   - SUM_W'(out_fire_c) + SUM_W'(in_fire_c);
        if (flush) begin
            if (kill_sum_c > SUM_W'(CNT_MAX)) kill_d = CNT_MAX;
            else                              kill_d = kill_sum_c[CNT_W-1:0];
        end
    end

    // Data and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
            kill_q      <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
            kill_q      <= kill_d;
        end
    end

    assign up.ready  = in_ready_q;
    assign dn.valid  = out_valid_q;
    assign dn.data   = out_data_q;
    assign occupancy = occupancy_q;
    assign kill_cnt  = kill_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, hand sequences for reset
// and saturation, then randomized traffic against a queue-based model.
// A second instance with a 2-bit kill counter shares the same stimulus.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic [1:0]        occ, occ2;
    logic [7:0]        kill;
    logic [1:0]        kill2;

    pipe_stage_skid_if #(.DATA_W(DATA_W)) up  ();
    pipe_stage_skid_if #(.DATA_W(DATA_W)) dn  ();
    pipe_stage_skid_if #(.DATA_W(DATA_W)) up2 ();
    pipe_stage_skid_if #(.DATA_W(DATA_W)) dn2 ();

    assign up.valid  = in_valid;
    assign up.data   = in_data;
    assign dn.ready  = out_ready;
    assign up2.valid = in_valid;
    assign up2.data  = in_data;
    assign dn2.ready = out_ready;

    pipe_stage_skid #(.DATA_W(DATA_W), .ZERO_BUBBLE(1'b1), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (up),
        .dn        (dn),
        .occupancy (occ),
        .kill_cnt  (kill)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .ZERO_BUBBLE(1'b1), .CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (up2),
        .dn        (dn2),
        .occupancy (occ2),
        .kill_cnt  (kill2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of accepted payloads (capacity 2) and an unbounded kill total.
    logic [DATA_W-1:0] mq[$];
    int                mk;

    typedef struct {
        logic        f;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ev;
        logic        er;
        logic [1:0]  eo;
        logic [31:0] ed;
        int          ek;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic cycle(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
        logic in_fire, out_fire;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        in_fire   = iv && (mq.size() < 2);
        out_fire  = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (f) begin
            mk += mq.size() - int'(out_fire) + int'(in_fire);
            mq.delete();
        end else begin
            if (out_fire) void'(mq.pop_front());
            if (in_fire)  mq.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : 32'h0;
        chk({tag, ".out_valid"}, 32'(dn.valid),  32'(mq.size() > 0));
        chk({tag, ".in_ready"},  32'(up.ready),  32'(mq.size() < 2));
        chk({tag, ".occupancy"}, 32'(occ),       32'(mq.size()));
        chk({tag, ".out_data"},  dn.data,        exp_d);
        chk({tag, ".kill_cnt"},  32'(kill),      32'(sat(mk, 255)));
        chk({tag, ".kill_sat"},  32'(kill2),     32'(sat(mk, 3)));
        chk({tag, ".sat_data"},  dn2.data,       exp_d);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mk = 0;
    endtask

    initial begin
        // Directed table: streaming, back-pressure, flush in FULL, flush with out_fire.
        tbl[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 2'd1, 32'h11, 0};
        tbl[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 2'd1, 32'h22, 0};
        tbl[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 2'd1, 32'h33, 0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0,  0};
        tbl[4]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA1, 0};
        tbl[5]  = '{1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA1, 0};
        tbl[6]  = '{1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA1, 0};
        tbl[7]  = '{1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA2, 0};
        tbl[8]  = '{1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA3, 0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0,  0};
        tbl[10] = '{1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB1, 0};
        tbl[11] = '{1'b0, 1'b1, 32'hB2, 1'b0, 1'b1, 1'b0, 2'd2, 32'hB1, 0};
        tbl[12] = '{1'b1, 1'b1, 32'hB3, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  2};
        tbl[13] = '{1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hC1, 2};
        tbl[14] = '{1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,  3};
        tbl[15] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  3};
        tbl[16] = '{1'b1, 1'b1, 32'hD1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  4};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0,  4};

        do_reset();
        chk("rst.out_valid", 32'(dn.valid), 32'h0);
        chk("rst.in_ready",  32'(up.ready), 32'h1);
        chk("rst.occupancy", 32'(occ),      32'h0);
        chk("rst.out_data",  dn.data,       32'h0);
        chk("rst.kill_cnt",  32'(kill),     32'h0);

        for (int i = 0; i < 18; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk({tag, ".out_valid"}, 32'(dn.valid), 32'(tbl[i].ev));
            chk({tag, ".in_ready"},  32'(up.ready), 32'(tbl[i].er));
            chk({tag, ".occupancy"}, 32'(occ),      32'(tbl[i].eo));
            chk({tag, ".out_data"},  dn.data,       tbl[i].ed);
            chk({tag, ".kill_cnt"},  32'(kill),     32'(tbl[i].ek));
            chk({tag, ".kill_sat"},  32'(kill2),    32'(sat(tbl[i].ek, 3)));
        end

        // Saturation: three flushes from FULL; 2-bit counter reads 2, 3, 3.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b1, 32'h100 + 32'(n), 1'b0);
            cycle(1'b0, 1'b1, 32'h200 + 32'(n), 1'b0);
            chk("sat.full_occ", 32'(occ2), 32'd2);
            cycle(1'b1, 1'b1, 32'h300, 1'b0);
            chk($sformatf("sat.kill2_%0d", n), 32'(kill2), (n == 0) ? 32'd2 : 32'd3);
            chk($sformatf("sat.kill8_%0d", n), 32'(kill),  32'(2 * (n + 1)));
        end

        // Reset asserted mid-cycle while FULL with a non-zero kill count.
        do_reset();
        cycle(1'b0, 1'b1, 32'hE1, 1'b0);
        cycle(1'b0, 1'b1, 32'hE2, 1'b0);
        cycle(1'b1, 1'b0, 32'h0,  1'b0);
        cycle(1'b0, 1'b1, 32'hE3, 1'b0);
        cycle(1'b0, 1'b1, 32'hE4, 1'b0);
        chk("midrst.pre_occ",  32'(occ),  32'd2);
        chk("midrst.pre_kill", 32'(kill), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 32'(dn.valid), 32'h0);
        chk("midrst.in_ready",  32'(up.ready), 32'h1);
        chk("midrst.occupancy", 32'(occ),      32'h0);
        chk("midrst.out_data",  dn.data,       32'h0);
        chk("midrst.kill_cnt",  32'(kill),     32'h0);
        chk("midrst.kill_sat",  32'(kill2),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mk = 0;

        // Randomized traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            logic f, iv, ordy;
            f    = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            cycle(f, iv, $urandom(), ordy);
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
